// File: rtl/uart_tx.sv
// UART transmitter: ready/valid parallel word in, async serial frame out.
// Frame = start, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
module uart_tx #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic                 write_valid,
  output logic                 write_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic ODD = (PARITY == 2);

  generate
    if (CPB < 2) begin : g_bad_cpb
      $error("uart_tx: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_tx: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state, w_nstate;
  logic [CW-1:0]        r_baud, w_nbaud;
  logic [BW-1:0]        r_bit, w_nbit;
  logic [DATA_BITS-1:0] r_shift, w_nshift;
  logic                 r_par, w_npar;
  logic                 r_tx, w_ntx;
  logic                 w_baud_last;
  logic                 w_stop_last;
  logic                 w_hs;

  assign w_baud_last = (r_baud == CW'(CPB - 1));
  assign w_stop_last = (r_state == S_STOP) && w_baud_last &&
                       (r_bit == BW'(STOP_BITS - 1));
  assign write_ready = !rst && ((r_state == S_IDLE) || w_stop_last);
  assign w_hs        = write_valid && write_ready;
  assign tx          = r_tx;
  assign busy        = (r_state != S_IDLE);

  // tx is registered from its next value, so the start bit
  // appears on the handshake edge itself.
  always_comb begin
    w_nstate = r_state;
    w_nbaud  = r_baud;
    w_nbit   = r_bit;
    w_nshift = r_shift;
    w_npar   = r_par;
    w_ntx    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_ntx = 1'b1;
        if (w_hs) begin
          w_nstate = S_START;
          w_nbaud  = '0;
          w_nshift = write_data;
          w_npar   = (^write_data) ^ ODD;
          w_ntx    = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_nstate = S_DATA;
          w_nbaud  = '0;
          w_nbit   = '0;
          w_ntx    = r_shift[0];
        end else begin
          w_nbaud = r_baud + CW'(1);
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_nbaud  = '0;
          w_nshift = r_shift >> 1;
          if (r_bit == BW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              w_nstate = S_PARITY;
              w_ntx    = r_par;
            end else begin
              w_nstate = S_STOP;
              w_nbit   = '0;
              w_ntx    = 1'b1;
            end
          end else begin
            w_nbit = r_bit + BW'(1);
            w_ntx  = r_shift[1];
          end
        end else begin
          w_nbaud = r_baud + CW'(1);
        end
      end
      S_PARITY: begin
        if (w_baud_last) begin
          w_nstate = S_STOP;
          w_nbaud  = '0;
          w_nbit   = '0;
          w_ntx    = 1'b1;
        end else begin
          w_nbaud = r_baud + CW'(1);
        end
      end
      S_STOP: begin
        w_ntx = 1'b1;
        if (w_baud_last) begin
          w_nbaud = '0;
          if (r_bit == BW'(STOP_BITS - 1)) begin
            if (w_hs) begin
              w_nstate = S_START;
              w_nshift = write_data;
              w_npar   = (^write_data) ^ ODD;
              w_ntx    = 1'b0;
            end else begin
              w_nstate = S_IDLE;
            end
          end else begin
            w_nbit = r_bit + BW'(1);
          end
        end else begin
          w_nbaud = r_baud + CW'(1);
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_nbaud  = '0;
        w_nbit   = '0;
        w_ntx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_baud  <= w_nbaud;
      r_bit   <= w_nbit;
      r_shift <= w_nshift;
      r_par   <= w_npar;
      r_tx    <= w_ntx;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations, frame-level reference model,
// directed frames with literal expectations, then randomized traffic.
module tb_uart_tx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] wd[4];
  logic       wv[4];
  logic       wr[4];
  logic       tx[4];
  logic       busy[4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
            .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .write_data(wd[0][7:0]), .write_valid(wv[0]),
    .write_ready(wr[0]), .tx(tx[0]), .busy(busy[0]));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
            .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .write_data(wd[1][7:0]), .write_valid(wv[1]),
    .write_ready(wr[1]), .tx(tx[1]), .busy(busy[1]));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
            .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .write_data(wd[2][7:0]), .write_valid(wv[2]),
    .write_ready(wr[2]), .tx(tx[2]), .busy(busy[2]));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
            .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .write_data(wd[3][6:0]), .write_valid(wv[3]),
    .write_ready(wr[3]), .tx(tx[3]), .busy(busy[3]));

  function automatic int cdb(int l);
    return (l == 3) ? 7 : 8;
  endfunction

  function automatic int cpar(int l);
    return (l == 1) ? 1 : ((l == 2) ? 2 : 0);
  endfunction

  function automatic int csb(int l);
    return (l == 3) ? 2 : 1;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %0h want %0h", n, $time, a, e);
    end
  endtask

  // Reference model: a frame is a list of line levels, one per bit
  // period; cycle k after the accepting edge shows level k/CPB.
  logic        m_on = 1'b0;
  logic        m_act[4];
  int          m_k[4];
  int          m_len[4];
  logic [15:0] m_fr[4];

  initial begin
    for (int l = 0; l < 4; l++) begin
      m_act[l] = 1'b0;
      m_k[l]   = 0;
      m_len[l] = 0;
      m_fr[l]  = '1;
    end
  end

  always @(posedge clk) begin : model
    logic er;
    logic p;
    int   n;
    if (rst) m_on = 1'b1;
    for (int l = 0; l < 4; l++) begin
      er = !rst && (!m_act[l] || m_k[l] == m_len[l] * CPB - 1);
      if (rst) begin
        m_act[l] = 1'b0;
      end else if (wv[l] && er) begin
        m_fr[l] = '1;
        m_fr[l][0] = 1'b0;
        p = 1'b0;
        for (int i = 0; i < cdb(l); i++) begin
          m_fr[l][1+i] = wd[l][i];
          p = p ^ wd[l][i];
        end
        n = 1 + cdb(l);
        if (cpar(l) != 0) begin
          m_fr[l][n] = (cpar(l) == 2) ? !p : p;
          n++;
        end
        m_len[l] = n + csb(l);
        m_k[l]   = 0;
        m_act[l] = 1'b1;
      end else if (m_act[l]) begin
        m_k[l]++;
        if (m_k[l] == m_len[l] * CPB) m_act[l] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      for (int l = 0; l < 4; l++) begin
        chk($sformatf("tx_l%0d", l), tx[l],
            m_act[l] ? m_fr[l][m_k[l]/CPB] : 1'b1);
        chk($sformatf("busy_l%0d", l), busy[l], m_act[l]);
        chk($sformatf("ready_l%0d", l), wr[l],
            !rst && (!m_act[l] || m_k[l] == m_len[l] * CPB - 1));
      end
    end
  end

  // Called at a negedge with wv/wd already driven; returns #1 after
  // the accepting edge.
  task automatic hs_wait(input int l);
    int w;
    w = 0;
    while (!wr[l] && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("hs_wait", w < 500, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input int l, input logic [8:0] d, input int len,
                     input int pk, output logic [15:0] b,
                     output int blen, output logic rlo, output logic rhi);
    b    = '1;
    blen = -1;
    rlo  = 1'bx;
    rhi  = 1'bx;
    wd[l] = d;
    wv[l] = 1'b1;
    hs_wait(l);
    wv[l] = 1'b0;
    wd[l] = 9'($urandom);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == pk) begin
        wv[l] = 1'b1;
        wd[l] = 9'h000;
      end
      if (k == pk + 1) wv[l] = 1'b0;
      if (k % CPB == CPB / 2 && k / CPB < 16) b[k/CPB] = tx[l];
      if (k == len - 2) rlo = wr[l];
      if (k == len - 1) rhi = wr[l];
      if (!busy[l]) begin
        blen = k;
        break;
      end
    end
  endtask

  logic [15:0] b;
  int          blen;
  logic        rlo, rhi;
  logic [9:0]  mp;

  initial begin
    for (int l = 0; l < 4; l++) begin
      wv[l] = 1'b0;
      wd[l] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_ready", wr[0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", wr[0], 1);

    // basic 8N1 frame of 0xA5
    cap(0, 9'h0A5, 100, -10, b, blen, rlo, rhi);
    chk("a5_bits", b[9:0], 10'b1101001010);
    chk("a5_len", blen, 100);
    chk("a5_rdy98", rlo, 0);
    chk("a5_rdy99", rhi, 1);
    for (int i = 0; i < 10; i++) mp[i] = m_fr[0][i];
    chk("model_a5", mp, 10'b1101001010);

    // parity variants
    cap(1, 9'h0A5, 110, -10, b, blen, rlo, rhi);
    chk("even_a5_par", b[9], 0);
    chk("even_a5_len", blen, 110);
    chk("even_rdy108", rlo, 0);
    chk("even_rdy109", rhi, 1);
    cap(2, 9'h0A5, 110, -10, b, blen, rlo, rhi);
    chk("odd_a5_par", b[9], 1);
    chk("odd_a5_len", blen, 110);
    cap(1, 9'h007, 110, -10, b, blen, rlo, rhi);
    chk("even_07_par", b[9], 1);
    chk("even_07_data", b[8:1], 8'h07);

    // 7 data bits, two stop bits
    cap(3, 9'h055, 100, -10, b, blen, rlo, rhi);
    chk("s2_data", b[7:1], 7'h55);
    chk("s2_stop", b[9:8], 2'b11);
    chk("s2_len", blen, 100);
    chk("s2_rdy98", rlo, 0);
    chk("s2_rdy99", rhi, 1);

    // back-to-back 0x00 then 0xFF with valid held high
    begin : b2b
      int   lowk;
      logic t95, t105, t155, r99;
      lowk = -1;
      wd[0] = 9'h000;
      wv[0] = 1'b1;
      hs_wait(0);
      wd[0] = 9'h0FF;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (k == 95) t95 = tx[0];
        if (k == 105) t105 = tx[0];
        if (k == 155) t155 = tx[0];
        if (k == 99) r99 = wr[0];
        if (!busy[0]) begin
          lowk = k;
          break;
        end
        if (k == 99) begin
          @(posedge clk);
          #1;
          wv[0] = 1'b0;
        end
      end
      chk("b2b_busy_len", lowk, 200);
      chk("b2b_stop1", t95, 1);
      chk("b2b_rdy_last_stop", r99, 1);
      chk("b2b_start2", t105, 0);
      chk("b2b_ff_bit", t155, 1);
    end

    // reset during data bit 3
    wd[0] = 9'h0A5;
    wv[0] = 1'b1;
    hs_wait(0);
    wv[0] = 1'b0;
    repeat (46) @(negedge clk);
    chk("pre_rst_busy", busy[0], 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tx", tx[0], 1);
    chk("abort_busy", busy[0], 0);
    chk("abort_ready", wr[0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", wr[0], 1);
    cap(0, 9'h03C, 100, -10, b, blen, rlo, rhi);
    chk("3c_bits", b[9:0], 10'b1001111000);
    chk("3c_len", blen, 100);

    // ignored data while idle, ignored pulse mid-frame
    begin : ign
      int lows;
      lows = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        wd[0] = ~wd[0];
        @(negedge clk);
        if (!tx[0]) lows++;
      end
      chk("idle_tx_low_cycles", lows, 0);
    end
    cap(0, 9'h0A5, 100, 30, b, blen, rlo, rhi);
    chk("pulse_bits", b[9:0], 10'b1101001010);
    chk("pulse_len", blen, 100);

    // randomized traffic on all lanes, occasional reset
    repeat (6000) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 499) == 0);
      for (int l = 0; l < 4; l++) begin
        wv[l] = ($urandom_range(0, 2) != 0);
        wd[l] = 9'($urandom);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int l = 0; l < 4; l++) wv[l] = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
